iic_byte_engine: RTL and testbench
==================================

# iic_byte_engine

Byte-level I2C master engine that sits directly below the I2C register file: the register file presents the start/stop/rw/data command fields and the clock divider, and this block sequences one byte on the bus. It generates SCL and open-drain SDA control for the pad buffer and returns busy/sending status and the received byte to the register file. Open-drain only: SDA is either driven low or released, never driven high.

## Interface
- No parameters; the bit rate comes from the `clkdiv` port.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: one-cycle command strobe; ignored while `busy`=1.
- `cmd_start` in 1: emit a START condition before the byte.
- `cmd_stop` in 1: emit a STOP condition after the ACK bit.
- `cmd_rw` in 1: 0 = write `din`; 1 = read a byte into `dout`.
- `ack_in` in 1: read only; 1 = master drives ACK (SDA low), 0 = NACK.
- `din` in 8: byte to transmit, MSB first.
- `clkdiv` in 8: quarter-bit length is `clkdiv`+1 clk cycles.
- `scl_i` in 1: SCL pad readback; used only with `IIC_CLK_STRETCH_EN`.
- `sda_i` in 1: SDA pad readback.
- `busy` out 1: a command is in progress.
- `sending` out 1: `busy` and the current command is a write.
- `done` out 1: one-cycle pulse in the final busy cycle.
- `dout` out 8: received byte.
- `ack_out` out 1: 1 = slave pulled SDA low in the ACK slot of a write.
- `sck` out 1: SCL.
- `sda_o` out 1: tied to 0.
- `sda_t` out 1: 1 = release SDA (input), 0 = drive low.

## Operation
- Reset values: `sck`=1, `sda_t`=1, `sda_o`=0, `busy`=0, `sending`=0, `done`=0, `dout`=0x00, `ack_out`=0.
- Command acceptance: a command is accepted when `cmd_valid` && !`busy`. On acceptance, latch `din`, `clkdiv`, `cmd_start`, `cmd_stop`, `cmd_rw` and `ack_in`. Later changes to these inputs have no effect until the next acceptance.
- States: IDLE → START (only if `cmd_start`) → BIT ×8 → ACK → STOP (only if `cmd_stop`) → IDLE.
- Every non-IDLE state lasts 4 quarters (q0–q3).
- START: q0 SDA released, SCL=1; q1 SDA low, SCL=1; q2 SDA low, SCL=1; q3 SDA low, SCL=0.
- BIT and ACK:
  - q0 and q1: SCL=0; SDA is set up at the start of q0.
  - q2 and q3: SCL=1.
  - `sda_i` is sampled on the first cycle of q3.
- SDA during BIT: write drives the latched bit (MSB first; release for 1, low for 0); read releases SDA and shifts the sample into `dout` LSB-first-in (MSB received first).
- SDA during ACK: write releases SDA and sets `ack_out` = !`sda_i`; read drives low if the latched `ack_in`=1, otherwise releases. `ack_out` is unchanged by reads.
- STOP: q0 SCL=0, SDA low; q1 SCL=1, SDA low; q2 SCL=1, SDA released; q3 SCL=1, SDA released.
- Without STOP: after ACK q3 the engine returns to IDLE holding SCL=0 and SDA released, so a repeated-START or next byte can follow.
- A START issued from this held state first raises SCL during its q0.
- `dout` is updated only by reads and is stable after `done`. `ack_out` holds until the next write's ACK sample.

## Timing
- Quarter prescaler: counts 0..`clkdiv`; a quarter ends when the count reaches the latched `clkdiv`.
- With `clkdiv`=0, every cycle is one quarter.
- Q = 4·(9 + `cmd_start` + `cmd_stop`).
- `busy` rises the cycle after acceptance and stays high for exactly Q·(`clkdiv`+1) cycles (excluding stretch).
- `done` is asserted in the final busy cycle. `busy` is low the following cycle, so a new command is accepted no earlier than that cycle.
- `sending` follows `busy` for writes.
- `cmd_valid` while busy is dropped, with no queuing.
- Reset mid-command: the next cycle is IDLE with the reset values above; the bus is released.

## Configuration
- `IIC_CLK_STRETCH_EN` defined: in any quarter where `sck`=1, the prescaler holds while `scl_i`=0. Busy time grows by the number of held cycles.
- `IIC_CLK_STRETCH_EN` undefined: `scl_i` is ignored, and timing is exactly as given in Timing.

## Structure
- Package `iic_pkg`:
  - state enum: IDLE, START, BIT, ACK, STOP;
  - quarter index constants;
  - IICCON bit positions for start/stop/rw/ack shared with the register file.
- Sub-module `iic_quarter_tick`: prescaler with `clkdiv` load, hold input (stretch) and a one-cycle tick output.
- The top level holds the FSM, the bit counter (3 bits) and the shift registers.

## Test plan
- Reset, then idle for 10 cycles → `sck`=1, `sda_t`=1, `busy`=0, `dout`=0x00.
- `clkdiv`=0, write 0xA5 with start+stop, slave model ACKs → `busy` high 44 cycles; SDA bit sequence 1,0,1,0,0,1,0,1; `ack_out`=1; `done` in cycle 44; STOP leaves SDA released.
- `clkdiv`=3, read with start, no stop, `ack_in`=0, slave drives 0x3C → `busy` high 160 cycles; `dout`=0x3C; SDA released in the ACK slot; `sck`=0 held afterwards.
- `cmd_valid` pulsed mid-command with `din`=0xFF → ignored; the original byte completes unchanged.
- `reset` asserted at BIT 4 → next cycle `busy`=0, `sck`=1, `sda_t`=1; a subsequent command runs normally.
- With `IIC_CLK_STRETCH_EN`, hold `scl_i`=0 for 7 cycles during BIT 2 q2 (`clkdiv`=0, start+stop) → `busy` lasts 51 cycles; data intact.

Source files
------------

// File: rtl/iic_pkg.sv
// iic_pkg: shared types and constants for the I2C byte engine and the I2C register file
//   iic_state_e  : byte engine sequencer states
//   quarter_e    : quarter index q0..q3 within every bus state
//   IICCON_*     : IICCON bit positions of the start/stop/rw/ack command fields
package iic_pkg;

    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} iic_state_e;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_e;

    localparam int IICCON_START = 0;
    localparam int IICCON_STOP  = 1;
    localparam int IICCON_RW    = 2;
    localparam int IICCON_ACK   = 3;

endpackage

// File: rtl/iic_quarter_tick.sv
// iic_quarter_tick: quarter-bit prescaler counting 0..div, producing a one-cycle tick per quarter
//   clk, reset : clock, synchronous active-high reset
//   en_i       : count while high; counter parks at 0 otherwise
//   load_i     : latch div_i as the quarter length (div_i+1 cycles)
//   hold_i     : freeze the counter (SCL stretching)
//   div_i      : quarter length minus one
//   tick_o     : last cycle of the current quarter
//   first_o    : first non-held cycle of the current quarter
module iic_quarter_tick (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic       load_i,
    input  logic       hold_i,
    input  logic [7:0] div_i,
    output logic       tick_o,
    output logic       first_o
);
    logic [7:0] div_q, cnt_q;

    assign tick_o  = en_i && !hold_i && cnt_q == div_q;
    // With a held counter the sample point moves to the cycle SCL is really high.
    assign first_o = en_i && !hold_i && cnt_q == 8'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            if (load_i) div_q <= div_i;
            if (!en_i) cnt_q <= '0;
            else if (!hold_i) cnt_q <= tick_o ? 8'd0 : cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/iic_byte_engine.sv
// iic_byte_engine: byte-level I2C master sequencing START, 8 data bits, ACK and STOP with open-drain SDA
//   clk, reset              : clock, synchronous active-high reset
//   cmd_valid               : command strobe, accepted only while idle
//   cmd_start/stop/rw       : START before byte, STOP after ACK, 0 = write din / 1 = read into dout
//   ack_in                  : read: 1 = master ACKs, 0 = NACK
//   din, clkdiv             : byte to send, quarter-bit length = clkdiv+1 cycles
//   scl_i, sda_i            : pad readback
//   busy, sending, done     : status; done pulses in the final busy cycle
//   dout, ack_out           : received byte, slave ACK seen by the last write
//   sck, sda_o, sda_t       : SCL, SDA output (always 0), SDA release (1 = released)
// Define IIC_CLK_STRETCH_EN to hold the prescaler while a slave keeps scl_i low in a high-SCL quarter.
module iic_byte_engine
    import iic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_rw,
    input  logic       ack_in,
    input  logic [7:0] din,
    input  logic [7:0] clkdiv,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       busy,
    output logic       sending,
    output logic       done,
    output logic [7:0] dout,
    output logic       ack_out,
    output logic       sck,
    output logic       sda_o,
    output logic       sda_t
);
    iic_state_e st_q, st_d;
    quarter_e   qt_q, qt_d;
    logic [2:0] bit_q, bit_d;
    logic [3:0] cmd_w;
    logic [7:0] tx_q, dout_q;
    logic       stop_q, rw_q, ack_q, ack_out_q, idle_low_q;
    logic       accept, tick, first, hold, last;

    always_comb begin
        cmd_w = '0;
        cmd_w[IICCON_START] = cmd_start;
        cmd_w[IICCON_STOP]  = cmd_stop;
        cmd_w[IICCON_RW]    = cmd_rw;
        cmd_w[IICCON_ACK]   = ack_in;
    end

    assign busy    = st_q != IDLE;
    assign accept  = cmd_valid && !busy;
    assign sending = busy && !rw_q;
    assign last    = qt_q == Q3 && (st_q == STOP || (st_q == ACK && !stop_q));
    assign done    = tick && last;
    assign dout    = dout_q;
    assign ack_out = ack_out_q;
    assign sda_o   = 1'b0;

`ifdef IIC_CLK_STRETCH_EN
    assign hold = sck && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign hold = 1'b0;
`endif

    iic_quarter_tick u_tick (
        .clk     (clk),
        .reset   (reset),
        .en_i    (busy),
        .load_i  (accept),
        .hold_i  (hold),
        .div_i   (clkdiv),
        .tick_o  (tick),
        .first_o (first)
    );

    always_comb begin
        st_d  = st_q;
        qt_d  = qt_q;
        bit_d = bit_q;
        if (accept) begin
            st_d  = cmd_w[IICCON_START] ? START : BIT;
            qt_d  = Q0;
            bit_d = '0;
        end else if (tick) begin
            qt_d = quarter_e'(qt_q + 2'd1);
            if (qt_q == Q3) begin
                case (st_q)
                    START: st_d = BIT;
                    BIT: begin
                        bit_d = bit_q + 3'd1;
                        st_d  = (bit_q == 3'd7) ? ACK : BIT;
                    end
                    ACK:     st_d = stop_q ? STOP : IDLE;
                    default: st_d = IDLE;
                endcase
            end
        end
    end

    // Idle SCL is high after reset/STOP and parked low after a byte without STOP.
    always_comb begin
        sck   = !idle_low_q;
        sda_t = 1'b1;
        case (st_q)
            START: begin
                sck   = qt_q != Q3;
                sda_t = qt_q == Q0;
            end
            BIT: begin
                sck   = qt_q >= Q2;
                sda_t = rw_q || tx_q[7];
            end
            ACK: begin
                sck   = qt_q >= Q2;
                sda_t = !(rw_q && ack_q);
            end
            STOP: begin
                sck   = qt_q != Q0;
                sda_t = qt_q >= Q2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= IDLE;
            qt_q       <= Q0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            tx_q       <= '0;
            dout_q     <= '0;
            ack_out_q  <= 1'b0;
            idle_low_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            qt_q  <= qt_d;
            bit_q <= bit_d;
            if (accept) begin
                stop_q <= cmd_w[IICCON_STOP];
                rw_q   <= cmd_w[IICCON_RW];
                ack_q  <= cmd_w[IICCON_ACK];
                tx_q   <= din;
            end else if (tick && st_q == BIT && qt_q == Q3) begin
                tx_q <= {tx_q[6:0], 1'b0};
            end
            if (first && qt_q == Q3) begin
                if (st_q == BIT && rw_q) dout_q <= {dout_q[6:0], sda_i};
                if (st_q == ACK && !rw_q) ack_out_q <= !sda_i;
            end
            if (done) idle_low_q <= !stop_q;
        end
    end

endmodule

// File: tb/tb_iic_byte_engine.sv
// tb_iic_byte_engine: table-driven bench for iic_byte_engine with a cycle-timed slave model
module tb_iic_byte_engine;

`ifdef IIC_CLK_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0, cmd_rw = 1'b0, ack_in = 1'b0;
    logic [7:0] din = 8'h00, clkdiv = 8'h00;
    logic       scl_i = 1'b1, slave_sda = 1'b1;
    logic       sda_i;
    logic       busy, sending, done, ack_out, sck, sda_o, sda_t;
    logic [7:0] dout;

    int checks = 0;
    int fails  = 0;

    assign sda_i = sda_t & slave_sda;

    iic_byte_engine dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_start (cmd_start),
        .cmd_stop  (cmd_stop),
        .cmd_rw    (cmd_rw),
        .ack_in    (ack_in),
        .din       (din),
        .clkdiv    (clkdiv),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .busy      (busy),
        .sending   (sending),
        .done      (done),
        .dout      (dout),
        .ack_out   (ack_out),
        .sck       (sck),
        .sda_o     (sda_o),
        .sda_t     (sda_t)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    typedef struct {
        logic       st, sp, rw, ak;
        logic [7:0] d, div, sb;
        logic       sa;
        int         poke, s_at, s_len, exp_busy;
        logic [7:0] exp_dout;
        logic       exp_ack_out, exp_sck_after, exp_ack_t;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n, qi, sub, slot, qq, qtot, sck_err, done_err, snd_err;
        logic exp_sck, stretched, last_m, ack_t;
        logic [7:0] seen;
        n = 0; qi = 0; sub = 0; sck_err = 0; done_err = 0; snd_err = 0;
        seen = 8'h00; ack_t = 1'bx;
        qtot = 4 * (9 + int'(v.st) + int'(v.sp));
        cmd_start = v.st; cmd_stop = v.sp; cmd_rw = v.rw; ack_in = v.ak;
        din = v.d; clkdiv = v.div; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (1) begin
            slot = qi / 4 - int'(v.st);
            qq = qi % 4;
            slave_sda = 1'b1;
            if (v.rw && slot >= 0 && slot <= 7) slave_sda = v.sb[7 - slot];
            else if (!v.rw && slot == 8) slave_sda = !v.sa;
            scl_i = !(n >= v.s_at && n < v.s_at + v.s_len);
            if (n == v.poke) begin
                cmd_valid = 1'b1; din = 8'hFF; cmd_rw = !v.rw; cmd_stop = !v.sp; clkdiv = 8'd5;
            end else begin
                cmd_valid = 1'b0;
            end
            #1;
            if (!busy) break;
            if (n > 5000) begin
                checks++; fails++;
                $display("FAIL busy_bound: busy still high after %0d cycles, required %0d", n, v.exp_busy);
                break;
            end
            exp_sck = (slot < 0) ? (qq != 3) : (slot <= 8) ? (qq >= 2) : (qq != 0);
            if (sck !== exp_sck) sck_err++;
            if (sending !== !v.rw) snd_err++;
            stretched = STRETCH && !scl_i && exp_sck;
            last_m = qi == qtot - 1 && sub == int'(v.div) && !stretched;
            if (done !== last_m) done_err++;
            if (qq == 2 && sub == 0 && slot >= 0 && slot <= 7) seen[7 - slot] = sda_t & slave_sda;
            if (qq == 2 && sub == 0 && slot == 8) ack_t = sda_t;
            if (!stretched) begin
                if (sub == int'(v.div)) begin
                    sub = 0;
                    qi++;
                end else begin
                    sub++;
                end
            end
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0; slave_sda = 1'b1; scl_i = 1'b1;
        check("busy_len", n, v.exp_busy);
        check("sda_bits", 32'(seen), 32'(v.rw ? v.sb : v.d));
        check("ack_slot_sda_t", 32'(ack_t), 32'(v.exp_ack_t));
        check("dout", 32'(dout), 32'(v.exp_dout));
        check("ack_out", 32'(ack_out), 32'(v.exp_ack_out));
        check("sck_after", 32'(sck), 32'(v.exp_sck_after));
        check("sda_t_after", 32'(sda_t), 1);
        check("sck_wave_errs", sck_err, 0);
        check("done_pulse_errs", done_err, 0);
        check("sending_errs", snd_err, 0);
    endtask

    initial begin
        vec_t v;
        //      st  sp  rw  ak  d      div    sb     sa  poke s_at s_len busy dout   ackout sck  ackt
        v = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 8'd0, 8'h00, 1'b1, 10, -1, 0, 44, 8'h00, 1'b1, 1'b1, 1'b1}; vecs.push_back(v);
        v = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'd3, 8'h3C, 1'b0, -1, -1, 0, 160, 8'h3C, 1'b1, 1'b0, 1'b1}; vecs.push_back(v);
        v = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 8'd1, 8'h00, 1'b0, -1, -1, 0, 80, 8'h3C, 1'b0, 1'b1, 1'b1}; vecs.push_back(v);
        v = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'd0, 8'h81, 1'b0, 5, -1, 0, 36, 8'h81, 1'b0, 1'b0, 1'b0}; vecs.push_back(v);
        v = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd2, 8'h00, 1'b1, -1, -1, 0, 132, 8'h81, 1'b1, 1'b1, 1'b1}; vecs.push_back(v);
        v = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'd0, 8'hFF, 1'b0, -1, -1, 0, 44, 8'hFF, 1'b1, 1'b1, 1'b0}; vecs.push_back(v);
`ifdef IIC_CLK_STRETCH_EN
        v = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 8'd0, 8'h00, 1'b1, -1, 14, 7, 51, 8'hFF, 1'b1, 1'b1, 1'b1}; vecs.push_back(v);
`endif

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("rst_sck", 32'(sck), 1);
        check("rst_sda_t", 32'(sda_t), 1);
        check("rst_sda_o", 32'(sda_o), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sending", 32'(sending), 0);
        check("rst_done", 32'(done), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_ack_out", 32'(ack_out), 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
            repeat (2) @(negedge clk);
        end

        cmd_start = 1'b1; cmd_stop = 1'b1; cmd_rw = 1'b0; din = 8'h96; clkdiv = 8'd0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("bit4_busy", 32'(busy), 1);
        check("bit4_sending", 32'(sending), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_sck", 32'(sck), 1);
        check("abort_sda_t", 32'(sda_t), 1);
        check("abort_done", 32'(done), 0);
        check("abort_dout", 32'(dout), 0);
        repeat (3) @(negedge clk);
        run_vec(vecs[0]);

        check("sda_o_tied", 32'(sda_o), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
